// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch back-end between PC generation and decode. Issues each accepted PC
//   to a synchronous instruction ROM (1-cycle read latency), buffers the
//   returned {instruction, PC} pairs in a DEPTH-entry FIFO and hands them to
//   decode over a valid/ready handshake. A flush discards queued and in-flight
//   fetches; pc_stall back-pressures the PC stage.
//
// Optional feature macro: IFQ_BYPASS_EN
//   When defined, a ROM response arriving into an empty queue with decode ready
//   is forwarded straight to the id_* outputs (latency T+1) without being
//   written to storage. When undefined, every entry passes through storage.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   pc_in, pc_valid     PC to fetch and its valid
//   pc_stall            queue cannot take a request; PC stage holds pc_in
//   flush               redirect: drop queued and in-flight fetches
//   imem_req/imem_addr  ROM read strobe and word address
//   imem_rdata          ROM data, valid the cycle after imem_req
//   id_valid/id_ready   decode handshake
//   id_instr/id_pc      head entry
//   id_pc_plus4         id_pc + 4 (mod 2^32)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_in,
  input  logic              pc_valid,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [31:0]      inflight_pc;

  logic             bypass;
  logic             pop;
  logic             pop_q;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // Forwarding path: response lands in an empty queue while decode is ready.
`ifdef IFQ_BYPASS_EN
  assign bypass = (count == '0) & inflight & ~flush & id_ready;
`else
  assign bypass = 1'b0;
`endif

  // Decode-side view of the head entry.
  always_comb begin
    id_valid = 1'b0;
    id_instr = instr_mem[rd_ptr];
    id_pc    = pc_mem[rd_ptr];
    if (rst_n) id_valid = (count != '0) | bypass;
    if (bypass) begin
      id_instr = imem_rdata;
      id_pc    = inflight_pc;
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;

  // A bypassed entry is consumed without touching storage or count.
  assign pop   = id_valid & id_ready;
  assign pop_q = pop & ~bypass;
  assign push  = inflight & ~flush & ~bypass;

  // Credit check counts the in-flight fetch and this cycle's pop; combinational
  // from id_ready so a full queue being drained can still accept a request.
  assign occ      = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign pc_stall = rst_n & (occ >= OCC_W'(DEPTH));

  assign issue     = rst_n & pc_valid & ~pc_stall & ~flush;
  assign imem_req  = issue;
  assign imem_addr = pc_in[ADDR_W+1:2];

  // Queue state, pointers and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop_q) rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count + CNT_W'(push) - CNT_W'(pop_q);
      inflight <= issue;
      if (issue) inflight_pc <= pc_in;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed scenarios followed by randomized traffic, all checked cycle by
//   cycle against a queue-based reference model of the fetch queue.
//   ROM model: word at address a holds 0x1000_0000 + a.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 14;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [31:0]       pc_in;
  logic              pc_valid;
  logic              pc_stall;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_plus4;

  int errors = 0;
  int checks = 0;

  // Reference model: queued PCs in fetch order plus the single outstanding fetch.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_of_pc(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_3FFF);
  endfunction

  // Synchronous ROM; junk when not strobed so a spurious write is visible.
  always @(posedge clk)
    imem_rdata <= imem_req ? (32'h1000_0000 + 32'(imem_addr)) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic pv, input logic [31:0] pc, input logic fl, input logic rdy);
    bit          byp, e_valid, pop, e_stall, issue;
    int          occ;
    logic [31:0] h_pc;
    @(negedge clk);
    pc_valid = pv;
    pc_in    = pc;
    flush    = fl;
    id_ready = rdy;
    #1;
    if (!rst_n) begin
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_pc_stall", 32'(pc_stall), 32'd0);
      @(posedge clk);
      mq.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
      return;
    end
    byp     = BYP && (mq.size() == 0) && m_infl && !fl && rdy;
    e_valid = (mq.size() != 0) || byp;
    h_pc    = byp ? m_infl_pc : ((mq.size() != 0) ? mq[0] : 32'h0);
    pop     = e_valid && rdy;
    occ     = mq.size() + int'(m_infl) - int'(pop);
    e_stall = occ >= int'(DEPTH);
    issue   = pv && !e_stall && !fl;

    check("id_valid", 32'(id_valid), 32'(e_valid));
    check("pc_stall", 32'(pc_stall), 32'(e_stall));
    check("imem_req", 32'(imem_req), 32'(issue));
    if (issue) check("imem_addr", 32'(imem_addr), (pc >> 2) & 32'h0000_3FFF);
    if (e_valid) begin
      check("id_pc", id_pc, h_pc);
      check("id_instr", id_instr, rom_of_pc(h_pc));
      check("id_pc_plus4", id_pc_plus4, h_pc + 32'd4);
    end

    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      if (pop && !byp) void'(mq.pop_front());
      if (m_infl && !byp) mq.push_back(m_infl_pc);
      m_infl = issue;
      if (issue) m_infl_pc = pc;
    end
  endtask

  logic [31:0] rpc;
  bit          rpv;

  initial begin
    rst_n    = 1'b0;
    pc_valid = 1'b0;
    pc_in    = '0;
    flush    = 1'b0;
    id_ready = 1'b0;
    mq.delete();
    m_infl    = 1'b0;
    m_infl_pc = '0;

    // Reset held two cycles with requests present.
    step(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0104, 1'b0, 1'b1);
    @(negedge clk);
    rst_n    = 1'b1;
    pc_valid = 1'b0;
    #1;
    check("post_rst_id_valid", 32'(id_valid), 32'd0);
    check("post_rst_id_pc", id_pc, 32'd0);
    check("post_rst_id_instr", id_instr, 32'd0);
    check("post_rst_plus4", id_pc_plus4, 32'd4);
    check("post_rst_pc_stall", 32'(pc_stall), 32'd0);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-pressure then drain (PC stage holds its PC while stalled).
    rpc = 32'h20;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rpc, 1'b0, 1'b0);
      if (!pc_stall && !flush) ;
      if (mq.size() + int'(m_infl) <= int'(DEPTH) && m_infl && m_infl_pc == rpc) rpc = rpc + 32'd4;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush kills the in-flight fetch; the next request proceeds normally.
    step(1'b1, 32'h10, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // PC at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Fill to DEPTH, then pop and request in the same cycle.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b1);
    step(1'b1, 32'h10C, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic; a stalled PC is held until accepted.
    rpc = 32'h0000_1000;
    rpv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit fl, rdy;
      if (!rpv) begin
        rpv = ($urandom_range(0, 9) < 7);
        rpc = ($urandom_range(0, 3) == 0) ? $urandom : rpc + 32'd4;
      end
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      step(rpv, rpc, fl, rdy);
      // Accepted if the model recorded it as the new in-flight fetch.
      if (rpv && !fl && m_infl && m_infl_pc == rpc) rpv = 1'b0;
      else if (fl) rpv = 1'b0;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
